// File: rtl/mini_alu_16bit_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mini_alu_16bit_div_ctrl
//  Purpose  : Upstream issue controller for the mini ALU divider. Queues
//             divide requests in a small FIFO, issues one start pulse per
//             request, captures quotient/remainder, resolves divide-by-zero
//             locally and aborts a hung divide after TIMEOUT cycles.
//  Ports    : clk, rst (async, active-low)
//             in_valid/in_ready/in_x/in_y         request port
//             div_start/div_x/div_y               divider issue port
//             div_valid/div_quot/div_rem          divider result port
//             out_valid/out_ready/out_quot/out_rem/out_dz/out_tmo  result port
//             busy                                work queued or in flight
//  Revision : 1.0  initial release
// ============================================================================
module mini_alu_16bit_div_ctrl #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic             div_start,
    output logic [WIDTH-1:0] div_x,
    output logic [WIDTH-1:0] div_y,
    input  logic             div_valid,
    input  logic [WIDTH-1:0] div_quot,
    input  logic [WIDTH-1:0] div_rem,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quot,
    output logic [WIDTH-1:0] out_rem,
    output logic             out_dz,
    output logic             out_tmo,
    output logic             busy
);

    localparam int            c_aw       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            c_tw       = $clog2(TIMEOUT + 1);
    localparam logic [c_aw:0] c_full     = (c_aw + 1)'(DEPTH);
    localparam logic [c_tw-1:0] c_tmo_last = c_tw'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_mem_x [DEPTH];
    logic [WIDTH-1:0] r_mem_y [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;

    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic [WIDTH-1:0] w_head_x;
    logic [WIDTH-1:0] w_head_y;

    assign in_ready = (r_count != c_full);
    assign w_empty  = (r_count == '0);
    assign w_push   = in_valid && in_ready;
    assign w_head_x = r_mem_x[r_rd_ptr];
    assign w_head_y = r_mem_y[r_rd_ptr];

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_x[r_wr_ptr] <= in_x;
            r_mem_y[r_wr_ptr] <= in_y;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_next;
    logic             w_issue;
    logic             w_dz;
    logic             w_done;
    logic             w_tmo;

    logic             r_div_start;
    logic             r_div_valid_q;
    logic [c_tw-1:0]  r_timer;
    logic [WIDTH-1:0] r_div_x;
    logic [WIDTH-1:0] r_div_y;
    logic [WIDTH-1:0] r_out_quot;
    logic [WIDTH-1:0] r_out_rem;
    logic             r_out_dz;
    logic             r_out_tmo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_pop   = 1'b0;
        w_issue = 1'b0;
        w_dz    = 1'b0;
        w_done  = 1'b0;
        w_tmo   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head_y == '0) begin
                        w_dz   = 1'b1;
                        w_next = S_OUT;
                    end else begin
                        w_issue = 1'b1;
                        w_next  = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // A level left high by the divider must not count as
                // completion, so only a fresh rising edge after the start
                // pulse is accepted.
                if (!r_div_start && div_valid && !r_div_valid_q) begin
                    w_done = 1'b1;
                    w_next = S_OUT;
                end else if (r_timer == c_tmo_last) begin
                    w_tmo  = 1'b1;
                    w_next = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Divider issue, timer and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_start   <= 1'b0;
            r_div_valid_q <= 1'b0;
            r_timer       <= '0;
            r_div_x       <= '0;
            r_div_y       <= '0;
            r_out_quot    <= '0;
            r_out_rem     <= '0;
            r_out_dz      <= 1'b0;
            r_out_tmo     <= 1'b0;
        end else begin
            r_div_start   <= w_issue;
            r_div_valid_q <= div_valid;

            if (w_issue) begin
                r_div_x <= w_head_x;
                r_div_y <= w_head_y;
            end

            if (w_issue)                r_timer <= '0;
            else if (r_state == S_WAIT) r_timer <= r_timer + 1'b1;

            if (w_dz) begin
                r_out_quot <= '1;
                r_out_rem  <= w_head_x;
                r_out_dz   <= 1'b1;
                r_out_tmo  <= 1'b0;
            end else if (w_done) begin
                r_out_quot <= div_quot;
                r_out_rem  <= div_rem;
                r_out_dz   <= 1'b0;
                r_out_tmo  <= 1'b0;
            end else if (w_tmo) begin
                r_out_quot <= '0;
                r_out_rem  <= '0;
                r_out_dz   <= 1'b0;
                r_out_tmo  <= 1'b1;
            end
        end
    end

    assign div_start = r_div_start;
    assign div_x     = r_div_x;
    assign div_y     = r_div_y;
    assign out_valid = (r_state == S_OUT);
    assign out_quot  = r_out_quot;
    assign out_rem   = r_out_rem;
    assign out_dz    = r_out_dz;
    assign out_tmo   = r_out_tmo;
    assign busy      = !w_empty || (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mini_alu_16bit_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mini_alu_16bit_div_ctrl
//  Purpose  : Self-checking bench for mini_alu_16bit_div_ctrl with a
//             behavioural divider and a result scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mini_alu_16bit_div_ctrl;

    localparam int WIDTH   = 16;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 48;
    localparam int LAT     = 3;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dz;
        logic             tmo;
    } res_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic             div_start;
    logic [WIDTH-1:0] div_x;
    logic [WIDTH-1:0] div_y;
    logic             div_valid;
    logic [WIDTH-1:0] div_quot;
    logic [WIDTH-1:0] div_rem;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_quot;
    logic [WIDTH-1:0] out_rem;
    logic             out_dz;
    logic             out_tmo;
    logic             busy;

    int   n_checks;
    int   n_pass;
    int   starts;
    bit   stall;
    res_t sb[$];

    mini_alu_16bit_div_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .div_start(div_start), .div_x(div_x), .div_y(div_y),
        .div_valid(div_valid), .div_quot(div_quot), .div_rem(div_rem),
        .out_valid(out_valid), .out_ready(out_ready), .out_quot(out_quot),
        .out_rem(out_rem), .out_dz(out_dz), .out_tmo(out_tmo), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural divider: result LAT cycles after start, valid level held
    // for two cycles. stall suppresses the result entirely.
    initial begin : divider_model
        logic [WIDTH-1:0] lx;
        logic [WIDTH-1:0] ly;
        int dcnt;
        int dhold;
        div_valid = 1'b0; div_quot = '0; div_rem = '0;
        lx = '0; ly = '0; dcnt = 0; dhold = 0; starts = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                div_valid = 1'b0; dcnt = 0; dhold = 0;
            end else if (div_start) begin
                starts++; lx = div_x; ly = div_y; dcnt = LAT;
            end else if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0 && !stall) begin
                    div_valid = 1'b1; div_quot = lx / ly; div_rem = lx % ly; dhold = 2;
                end
            end else if (dhold > 0) begin
                dhold--;
                if (dhold == 0) div_valid = 1'b0;
            end
        end
    end

    function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        res_t m;
        if (y == '0) begin m.q = '1;    m.r = x;     m.dz = 1'b1; end
        else         begin m.q = x / y; m.r = x % y; m.dz = 1'b0; end
        m.tmo = 1'b0;
        return m;
    endfunction

    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input bit tmo_exp);
        bit   acc;
        res_t e;
        acc = 1'b0; in_x = x; in_y = y; in_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            $display("FAIL send_accept x=%0d y=%0d: in_ready stayed 0, required 1", x, y);
        end else begin
            if (tmo_exp) begin e.q = '0; e.r = '0; e.dz = 1'b0; e.tmo = 1'b1; end
            else e = model(x, y);
            sb.push_back(e);
        end
    endtask

    // Waits (bounded) for out_valid and completes one handshake; out_ready
    // must already be 1.
    task automatic get_result(input int budget, output res_t res, output bit got);
        got = 1'b0; res = '0;
        for (int i = 0; i < budget && !got; i++) begin
            if (out_valid) begin
                res = {out_quot, out_rem, out_dz, out_tmo};
                got = 1'b1;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (div_start !== 1'b0) $display("FAIL rst_div_start got %b exp 0", div_start); else n_pass++;
        n_checks++; if ({div_x, div_y} !== 32'd0) $display("FAIL rst_div_xy got %h exp 0", {div_x, div_y}); else n_pass++;
        n_checks++; if ({out_quot, out_rem, out_dz, out_tmo} !== 34'd0)
            $display("FAIL rst_out_regs got %h exp 0", {out_quot, out_rem, out_dz, out_tmo}); else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", in_ready); else n_pass++;
    endtask

    task automatic test_single();
        res_t got_r, e;
        bit   got;
        int   s0;
        s0 = starts; out_ready = 1'b1;
        fork
            send(16'd15, 16'd8, 1'b0);
            get_result(100, got_r, got);
        join
        n_checks++; if (!got) $display("FAIL t1_result_timeout got none exp one result"); else n_pass++;
        e = sb.pop_front();
        n_checks++; if (got_r !== e) $display("FAIL t1_result got %h exp %h", got_r, e); else n_pass++;
        n_checks++; if (starts - s0 !== 1) $display("FAIL t1_start_pulses got %0d exp 1", starts - s0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        res_t r0, r1, r2, e;
        bit   g0, g1, g2;
        out_ready = 1'b1;
        fork
            begin
                send(16'd10, 16'd2, 1'b0);
                send(16'd89, 16'd21, 1'b0);
                send(16'd0, 16'd20, 1'b0);
            end
            begin
                get_result(100, r0, g0);
                get_result(100, r1, g1);
                get_result(100, r2, g2);
            end
        join
        n_checks++; if (!(g0 && g1 && g2)) $display("FAIL t2_results_seen got %b%b%b exp 111", g0, g1, g2); else n_pass++;
        e = sb.pop_front(); n_checks++; if (r0 !== e) $display("FAIL t2_res0 got %h exp %h", r0, e); else n_pass++;
        e = sb.pop_front(); n_checks++; if (r1 !== e) $display("FAIL t2_res1 got %h exp %h", r1, e); else n_pass++;
        e = sb.pop_front(); n_checks++; if (r2 !== e) $display("FAIL t2_res2 got %h exp %h", r2, e); else n_pass++;
    endtask

    task automatic test_div_zero();
        res_t got_r, e;
        bit   got;
        int   s0;
        s0 = starts; out_ready = 1'b1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL t3_in_ready got %b exp 1", in_ready); else n_pass++;
        in_x = 16'd77; in_y = 16'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb.push_back(model(16'd77, 16'd0));
        n_checks++; if (out_valid !== 1'b0) $display("FAIL t3_lat1_valid got %b exp 0", out_valid); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL t3_lat2_valid got %b exp 1", out_valid); else n_pass++;
        get_result(10, got_r, got);
        e = sb.pop_front();
        n_checks++; if (got_r !== e) $display("FAIL t3_result got %h exp %h", got_r, e); else n_pass++;
        n_checks++; if (starts !== s0) $display("FAIL t3_no_start got %0d exp %0d", starts, s0); else n_pass++;
    endtask

    task automatic test_backpressure();
        res_t got_r, e;
        bit   got;
        int   n;
        out_ready = 1'b0;
        send(16'd1000, 16'd7, 1'b0);
        send(16'd65535, 16'd256, 1'b0);
        send(16'd12, 16'd12, 1'b0);
        send(16'd5, 16'd0, 1'b0);
        send(16'd3, 16'd9, 1'b0);
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        n_checks++; if (out_valid !== 1'b1) $display("FAIL t4_first_out got %b exp 1", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL t4_full_in_ready got %b exp 0", in_ready); else n_pass++;
        in_x = 16'd44; in_y = 16'd4; in_valid = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        n_checks++; if (in_ready !== 1'b0) $display("FAIL t4_still_full got %b exp 0", in_ready); else n_pass++;
        n_checks++; if (!(out_valid === 1'b1 && {out_quot, out_rem, out_dz, out_tmo} === sb[0]))
            $display("FAIL t4_held_result got v=%b %h exp v=1 %h", out_valid, {out_quot, out_rem, out_dz, out_tmo}, sb[0]);
            else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL t4_busy got %b exp 1", busy); else n_pass++;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            get_result(100, got_r, got);
            e = sb.pop_front();
            n_checks++; if (!got || got_r !== e) $display("FAIL t4_drain%0d got %h (seen=%b) exp %h", k, got_r, got, e); else n_pass++;
        end
        n_checks++; if (busy !== 1'b0) $display("FAIL t4_idle_busy got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_timeout();
        res_t got_r, e;
        bit   got;
        int   n, s0;
        s0 = starts; stall = 1'b1; out_ready = 1'b1;
        send(16'd100, 16'd7, 1'b1);
        n = 0;
        while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
        n_checks++; if (n !== TIMEOUT + 1) $display("FAIL t5_tmo_latency got %0d exp %0d", n, TIMEOUT + 1); else n_pass++;
        get_result(5, got_r, got);
        e = sb.pop_front();
        n_checks++; if (!got || got_r !== e) $display("FAIL t5_tmo_result got %h (seen=%b) exp %h", got_r, got, e); else n_pass++;
        n_checks++; if (starts - s0 !== 1) $display("FAIL t5_start_pulses got %0d exp 1", starts - s0); else n_pass++;
        stall = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        send(16'd50, 16'd6, 1'b0);
        get_result(100, got_r, got);
        e = sb.pop_front();
        n_checks++; if (!got || got_r !== e) $display("FAIL t5_after_tmo got %h (seen=%b) exp %h", got_r, got, e); else n_pass++;
    endtask

    task automatic test_reset_mid();
        res_t got_r, e;
        bit   got;
        int   seen;
        stall = 1'b1; out_ready = 1'b0;
        send(16'd1000, 16'd3, 1'b0);
        send(16'd20, 16'd4, 1'b0);
        send(16'd30, 16'd5, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        n_checks++; if (busy !== 1'b1) $display("FAIL t6_busy_before got %b exp 1", busy); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_checks++; if ({out_valid, busy, div_start, in_ready} !== 4'b0001)
            $display("FAIL t6_rst_ctrl got %b exp 0001", {out_valid, busy, div_start, in_ready}); else n_pass++;
        n_checks++; if ({div_x, div_y, out_quot, out_rem, out_dz, out_tmo} !== 66'd0)
            $display("FAIL t6_rst_data got %h exp 0", {div_x, div_y, out_quot, out_rem, out_dz, out_tmo}); else n_pass++;
        sb.delete();
        stall = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < TIMEOUT + 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_checks++; if (seen !== 0) $display("FAIL t6_stale_result got %0d results exp 0", seen); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL t6_busy_after got %b exp 0", busy); else n_pass++;
        send(16'd9, 16'd4, 1'b0);
        get_result(100, got_r, got);
        e = sb.pop_front();
        n_checks++; if (!got || got_r !== e) $display("FAIL t6_fresh got %h (seen=%b) exp %h", got_r, got, e); else n_pass++;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; stall = 1'b0;
        rst = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_div_zero();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
